// File: rtl/sw_pkg.sv
// Shared definitions for the switch debounce reader: channel count, FSM encoding,
// and the helper that sizes the shared counters.
package sw_pkg;

    localparam int NUM_SW = 2;

    typedef enum logic [1:0] {
        REL     = 2'd0,
        REL_CHK = 2'd1,
        PRS     = 2'd2,
        PRS_CHK = 2'd3
    } sw_state_e;

    function automatic int sw_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One switch channel: 2-FF synchroniser, debounce FSM, registered level/press/release.
// Long-press hold counter is built only when SWITCH_LONGPRESS_EN is defined.
module debounce_chan
    import sw_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = 120000,
    parameter int LONGPRESS_CYCLES = 12000000
) (
    input  logic clk,
    input  logic rstn,
    input  logic sw_raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    localparam int CNT_W = $clog2(sw_max(DEBOUNCE_CYCLES, LONGPRESS_CYCLES) + 1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    sw_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            state_q   <= REL;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= sw_raw_i;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // The counter restarts from zero on every state change, so a bounce restarts the window.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            REL: begin
                if (sync2_q) begin
                    state_d = REL_CHK;
                    cnt_d   = '0;
                end
            end
            REL_CHK: begin
                if (!sync2_q) begin
                    state_d = REL;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = PRS;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRS: begin
                if (!sync2_q) begin
                    state_d = PRS_CHK;
                    cnt_d   = '0;
                end
            end
            PRS_CHK: begin
                if (sync2_q) begin
                    state_d = PRS;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d   = REL;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = REL;
                cnt_d   = '0;
            end
        endcase
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

`ifdef SWITCH_LONGPRESS_EN
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(LONGPRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_DONE = CNT_W'(LONGPRESS_CYCLES);

    logic [CNT_W-1:0] hold_q, hold_d;
    logic             long_q, long_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    // Counts only while stably pressed; parking at LP_DONE guarantees one pulse per press.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (state_q == PRS) begin
            if (hold_q == LP_LAST) begin
                hold_d = LP_DONE;
                long_d = 1'b1;
            end else if (hold_q < LP_LAST) begin
                hold_d = hold_q + 1'b1;
            end
        end else if (state_d == REL) begin
            hold_d = '0;
        end
    end

    assign long_o = long_q;
`else
    assign long_o = 1'b0;
`endif

endmodule

// File: rtl/switch_debounce_reader.sv
// Board switch front end: one debounce_chan per switch, outputs concatenated
// (bit0 = SW1, bit1 = SW2). Long-press pulses need SWITCH_LONGPRESS_EN.
module switch_debounce_reader
    import sw_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = 120000,
    parameter int LONGPRESS_CYCLES = 12000000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              SW1,
    input  logic              SW2,
    output logic [NUM_SW-1:0] sw_level,
    output logic [NUM_SW-1:0] sw_press,
    output logic [NUM_SW-1:0] sw_release,
    output logic [NUM_SW-1:0] sw_long
);

    logic [NUM_SW-1:0] sw_raw;
    assign sw_raw = {SW2, SW1};

    for (genvar g = 0; g < NUM_SW; g++) begin : g_chan
        debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONGPRESS_CYCLES(LONGPRESS_CYCLES)
        ) u_chan (
            .clk      (clk),
            .rstn     (rstn),
            .sw_raw_i (sw_raw[g]),
            .level_o  (sw_level[g]),
            .press_o  (sw_press[g]),
            .release_o(sw_release[g]),
            .long_o   (sw_long[g])
        );
    end

endmodule
